// File: rtl/avst_pkt_arb_pkg.sv
// Shared types, constants and round-robin search helper for the Avalon-ST packet arbiter.
package avst_pkt_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned CNT_WIDTH = 32;
    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    // One-hot pick of the first requester at or after (last+1) mod num, scanning upward.
    function automatic logic [MAX_REQ-1:0] rr_search(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_IDX_W-1:0] last,
        input int unsigned          num
    );
        logic [MAX_REQ-1:0] win;
        logic               found;
        int unsigned        idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = (32'(last) + k) % num;
            if (k <= num && !found && req[idx[MAX_IDX_W-1:0]]) begin
                win[idx[MAX_IDX_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/avst_pkt_arbiter_rr.sv
// Combinational round-robin priority pick: one-hot winner searched upward from last_winner+1.
module rr_arbiter
    import avst_pkt_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner_c
);

    assign winner_c = NUM_REQ'(rr_search(MAX_REQ'(req), MAX_IDX_W'(last_winner), NUM_REQ));

endmodule

// File: rtl/avst_pkt_arbiter.sv
// Packet-atomic round-robin merge of NUM_REQ Avalon-ST sources onto one output, zero-latency datapath.
// Optional per-requester packet counters on pkt_cnt when AVST_PKT_ARB_STATS_EN is defined.
module avst_pkt_arbiter
    import avst_pkt_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            in_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_sof,
    input  logic [NUM_REQ-1:0]            in_eof,
    output logic [NUM_REQ-1:0]            in_rdy,
    output logic                          out_vld,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_sof,
    output logic                          out_eof,
    input  logic                          out_rdy,
    output logic [NUM_REQ-1:0]            gnt
`ifdef AVST_PKT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  pkt_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t               state;
    state_t               state_nxt;
    logic [NUM_REQ-1:0]   gnt_nxt;
    logic [NUM_REQ-1:0]   win_c;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     owner_nxt;
    logic [IDX_W-1:0]     last_winner;
    logic [IDX_W-1:0]     last_nxt;
    logic                 done_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req         (in_vld),
        .last_winner (last_winner),
        .winner_c    (win_c)
    );

    // Owner-to-output mux; everything is held at zero while no packet owns the output.
    always_comb begin
        out_vld  = 1'b0;
        out_sof  = 1'b0;
        out_eof  = 1'b0;
        out_data = '0;
        in_rdy   = '0;
        if (state == LOCKED) begin
            out_vld  = in_vld[owner];
            out_sof  = in_sof[owner];
            out_eof  = in_eof[owner];
            out_data = in_data[32'(owner)*DATA_WIDTH +: DATA_WIDTH];
            in_rdy   = gnt & {NUM_REQ{out_rdy}};
        end
    end

    assign done_c = (state == LOCKED) && out_vld && out_rdy && out_eof;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        last_nxt  = last_winner;
        case (state)
            IDLE: begin
                if (|in_vld) begin
                    state_nxt = LOCKED;
                    gnt_nxt   = win_c;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (win_c[i]) begin
                            owner_nxt = IDX_W'(i);
                        end
                    end
                end
            end
            LOCKED: begin
                if (done_c) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    last_nxt  = owner;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            owner       <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            owner       <= owner_nxt;
            last_winner <= last_nxt;
        end
    end

`ifdef AVST_PKT_ARB_STATS_EN
    // Completed-packet counters, wrapping naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (done_c) begin
            pkt_cnt[32'(owner)*CNT_WIDTH +: CNT_WIDTH] <=
                pkt_cnt[32'(owner)*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_avst_pkt_arbiter.sv
// Self-checking bench for avst_pkt_arbiter: vector table, directed corner sequences, random traffic vs model.
module tb_avst_pkt_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_vld, in_sof, in_eof, in_rdy, gnt;
    logic [N*DW-1:0] in_data;
    logic            out_vld, out_sof, out_eof, out_rdy;
    logic [DW-1:0]   out_data;
`ifdef AVST_PKT_ARB_STATS_EN
    logic [N*32-1:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    avst_pkt_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .in_eof   (in_eof),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_sof  (out_sof),
        .out_eof  (out_eof),
        .out_rdy  (out_rdy),
        .gnt      (gnt)
`ifdef AVST_PKT_ARB_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: current owner (-1 = none), last winner, completed-packet counts.
    int          owner_m;
    int          last_m;
    int unsigned cnt_m[N];
    logic [N-1:0] exp_irdy;

    // Packet sources
    int  len[N], beat[N], seq[N], len_cfg[N];
    bit  en[N];
    int  vld_pct = 100;
    int  rdy_pct = 100;
    int  done_q[$];

    typedef struct {
        logic       rst_n;
        logic [3:0] vld, sof, eof;
        logic       ordy;
        logic [3:0] e_gnt;
        logic       e_ovld, e_osof, e_oeof;
        logic [3:0] e_irdy;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] src_data(input int i);
        return {8'(i), 8'(seq[i]), 16'(beat[i])};
    endfunction

    function automatic int new_len(input int i);
        return (len_cfg[i] > 0) ? len_cfg[i] : int'($urandom_range(1, 4));
    endfunction

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            in_vld[i] = en[i] && ($urandom_range(99) < vld_pct);
            in_sof[i] = (beat[i] == 0);
            in_eof[i] = (beat[i] == len[i] - 1);
            in_data[i*DW +: DW] = src_data(i);
        end
        out_rdy = ($urandom_range(99) < rdy_pct);
    endtask

    // Compare DUT against the model for this cycle, then advance model and sources across the edge.
    task automatic tick();
        logic [N-1:0] eg;
        logic         ev;
        bit           found;
        int           idx;
        #1;
        if (owner_m < 0) begin
            eg = '0; ev = 1'b0; exp_irdy = '0;
        end else begin
            eg = 4'(1 << owner_m);
            ev = in_vld[owner_m];
            exp_irdy = out_rdy ? eg : '0;
        end
        chk("gnt", 64'(gnt), 64'(eg));
        chk("out_vld", 64'(out_vld), 64'(ev));
        chk("in_rdy", 64'(in_rdy), 64'(exp_irdy));
        if (owner_m >= 0 && ev) begin
            chk("out_data", 64'(out_data), 64'(in_data[owner_m*DW +: DW]));
            chk("out_sof", 64'(out_sof), 64'(in_sof[owner_m]));
            chk("out_eof", 64'(out_eof), 64'(in_eof[owner_m]));
        end
`ifdef AVST_PKT_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("pkt_cnt", 64'(pkt_cnt[i*32 +: 32]), 64'(cnt_m[i]));
`endif
        if (out_vld && out_rdy && out_eof) begin
            idx = -1;
            for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
            done_q.push_back(idx);
        end
        @(posedge clk);
        if (!rst_n) begin
            owner_m = -1;
            last_m  = N - 1;
            for (int i = 0; i < N; i++) begin cnt_m[i] = 0; beat[i] = 0; end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (in_vld[i] && exp_irdy[i]) begin
                    if (beat[i] == len[i] - 1) begin
                        beat[i] = 0; seq[i]++; len[i] = new_len(i);
                    end else begin
                        beat[i]++;
                    end
                end
            end
            if (owner_m < 0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    idx = (last_m + k) % N;
                    if (!found && in_vld[idx]) begin owner_m = idx; found = 1; end
                end
            end else if (in_vld[owner_m] && out_rdy && in_eof[owner_m]) begin
                cnt_m[owner_m]++;
                last_m  = owner_m;
                owner_m = -1;
            end
        end
        #1;
    endtask

    task automatic src_cycle();
        drive_src();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) en[i] = 0;
        vld_pct = 100;
        rdy_pct = 100;
        src_cycle();
        rst_n = 1'b1;
        done_q.delete();
    endtask

    task automatic setup(input logic [N-1:0] mask, input int l);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                en[i] = 1; len_cfg[i] = l; len[i] = new_len(i);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_vld = '0; in_sof = '0; in_eof = '0; in_data = '0; out_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            len[i] = 1; beat[i] = 0; seq[i] = 0; len_cfg[i] = 1; en[i] = 0; cnt_m[i] = 0;
        end
        owner_m = -1; last_m = N - 1;
        repeat (2) @(posedge clk);
        #1;

        //            rst   vld    sof    eof    ordy  gnt    ovld  osof  oeof  irdy
        tbl[0]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b1, 4'h2, 4'h2, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[2]  = '{1'b1, 4'h2, 4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 4'h2};
        tbl[3]  = '{1'b1, 4'h2, 4'h0, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 4'h2};
        tbl[4]  = '{1'b1, 4'h2, 4'h0, 4'h2, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 4'h2};
        tbl[5]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[6]  = '{1'b1, 4'h5, 4'h5, 4'h5, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[7]  = '{1'b1, 4'h5, 4'h5, 4'h5, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 4'h4};
        tbl[8]  = '{1'b1, 4'h5, 4'h5, 4'h5, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[9]  = '{1'b1, 4'h5, 4'h5, 4'h5, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 4'h1};
        tbl[10] = '{1'b1, 4'h5, 4'h5, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[11] = '{1'b1, 4'h5, 4'h5, 4'h5, 1'b0, 4'h4, 1'b1, 1'b1, 1'b1, 4'h0};
        tbl[12] = '{1'b1, 4'h5, 4'h5, 4'h5, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 4'h4};

        for (int r = 0; r < 13; r++) begin
            rst_n = tbl[r].rst_n; in_vld = tbl[r].vld; in_sof = tbl[r].sof;
            in_eof = tbl[r].eof; out_rdy = tbl[r].ordy;
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'((i + 1) * 32'h0101_0101 + r);
            #2;
            chk($sformatf("tbl%0d_gnt", r), 64'(gnt), 64'(tbl[r].e_gnt));
            chk($sformatf("tbl%0d_ovld", r), 64'(out_vld), 64'(tbl[r].e_ovld));
            chk($sformatf("tbl%0d_irdy", r), 64'(in_rdy), 64'(tbl[r].e_irdy));
            if (tbl[r].e_ovld) begin
                chk($sformatf("tbl%0d_osof", r), 64'(out_sof), 64'(tbl[r].e_osof));
                chk($sformatf("tbl%0d_oeof", r), 64'(out_eof), 64'(tbl[r].e_oeof));
            end
            tick();
        end

        // All four streaming single-beat packets: 0,1,2,3,0,... with a bubble each
        do_reset();
        setup(4'hf, 1);
        repeat (16) src_cycle();
        chk("rr_count", 64'(done_q.size()), 64'd8);
        for (int k = 0; k < done_q.size() && k < 8; k++) chk("rr_order", 64'(done_q[k]), 64'(k % 4));

        // Requester 2 arrives mid-packet of requester 0; grant must not move until eof
        do_reset();
        setup(4'b0001, 5);
        for (int k = 0; k < 20 && beat[0] != 2; k++) src_cycle();
        chk("atomic_wait", 64'(beat[0]), 64'd2);
        setup(4'b0100, 1);
        for (int k = 0; k < 40 && done_q.size() < 2; k++) src_cycle();
        chk("atomic_count", 64'(done_q.size()), 64'd2);
        if (done_q.size() >= 2) begin
            chk("atomic_first", 64'(done_q[0]), 64'd0);
            chk("atomic_second", 64'(done_q[1]), 64'd2);
        end

        // Four-cycle backpressure stall mid-packet
        do_reset();
        setup(4'b0010, 5);
        for (int k = 0; k < 20 && beat[1] != 2; k++) src_cycle();
        chk("stall_wait", 64'(beat[1]), 64'd2);
        rdy_pct = 0;
        for (int c = 0; c < 4; c++) begin
            drive_src();
            #2;
            chk("stall_data", 64'(out_data), 64'({8'd1, 8'(seq[1]), 16'd2}));
            chk("stall_vld", 64'(out_vld), 64'd1);
            chk("stall_irdy", 64'(in_rdy), 64'd0);
            tick();
        end
        rdy_pct = 100;
        for (int k = 0; k < 20 && done_q.size() < 1; k++) src_cycle();
        chk("stall_done", 64'(done_q.size()), 64'd1);

        // Reset during beat 2 aborts the packet; requester 0 wins afterwards
        do_reset();
        setup(4'b0010, 5);
        for (int k = 0; k < 20 && beat[1] != 2; k++) src_cycle();
        chk("rst_wait", 64'(beat[1]), 64'd2);
        rst_n = 1'b0;
        src_cycle();
        rst_n = 1'b1;
        setup(4'b0001, 1);
        drive_src();
        #2;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_ovld", 64'(out_vld), 64'd0);
        chk("rst_irdy", 64'(in_rdy), 64'd0);
        tick();
        drive_src();
        #2;
        chk("rst_winner", 64'(gnt), 64'b0001);
        tick();

`ifdef AVST_PKT_ARB_STATS_EN
        // Five packets on requester 3 only
        do_reset();
        setup(4'b1000, 2);
        for (int k = 0; k < 60 && done_q.size() < 5; k++) src_cycle();
        en[3] = 0;
        drive_src();
        #2;
        for (int i = 0; i < N; i++) chk("stats_cnt", 64'(pkt_cnt[i*32 +: 32]), (i == 3) ? 64'd5 : 64'd0);
        tick();
`endif

        // Random traffic with random lengths, valids, backpressure and occasional reset
        do_reset();
        setup(4'hf, 0);
        vld_pct = 70;
        rdy_pct = 75;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(199) != 0);
            src_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/avst_pkt_arbiter.md
AVST_PKT_ARBITER -- requirements
Module: avst_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 512, giving the packet data bus width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requester streams (legal range 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous to clk and active-low.
REQ-005 The block SHALL have port in_vld, input, NUM_REQ bits: per-requester valid.
REQ-006 The block SHALL have port in_data, input, NUM_REQ*DATA_WIDTH bits: per-requester data; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 The block SHALL have ports in_sof and in_eof, input, NUM_REQ bits each: per-requester start-of-packet and end-of-packet.
REQ-008 The block SHALL have port in_rdy, output, NUM_REQ bits: per-requester ready.
REQ-009 The block SHALL have ports out_vld (1 bit), out_data (DATA_WIDTH bits), out_sof (1 bit) and out_eof (1 bit), all outputs: the merged source stream.
REQ-010 The block SHALL have port out_rdy, input, 1 bit: downstream ready.
REQ-011 The block SHALL have port gnt, output, NUM_REQ bits: one-hot current owner of the output, zero when idle.

Function
REQ-012 A beat SHALL transfer on any side only when vld and rdy are both high in the same cycle.
REQ-013 The state machine SHALL have two states, IDLE and LOCKED.
REQ-014 In IDLE with in_vld nonzero, the block SHALL select a winner by round-robin, searching upward from (last_winner+1) mod NUM_REQ.
REQ-015 The round-robin selection SHALL register the winner into gnt and move to LOCKED on the next edge, giving 1-cycle arbitration latency.
REQ-016 In IDLE, out_vld, in_rdy and gnt SHALL all be 0.
REQ-017 In LOCKED, out_vld/out_data/out_sof/out_eof SHALL combinationally equal the granted requester's inputs.
REQ-018 In LOCKED, in_rdy[g] SHALL equal out_rdy for the granted requester g; every other in_rdy bit SHALL be 0.
REQ-019 The block SHALL add zero-cycle datapath latency and no buffering.
REQ-020 On a transferred beat with eof=1, the block SHALL return to IDLE, clear gnt and record last_winner=g; each packet costs one idle bubble.
REQ-021 A single-beat packet (sof=eof=1) SHALL be granted and released like any other packet.
REQ-022 The grant SHALL be packet-atomic: it SHALL never change mid-packet, regardless of other requesters' valids.
REQ-023 If the granted requester drops in_vld mid-packet, the block SHALL stay LOCKED with out_vld=0.
REQ-024 The block SHALL NOT check sof; a requester granted without sof is forwarded unchanged.
REQ-025 While out_rdy=0, out_vld/out_data/out_sof/out_eof SHALL remain driven by the owner and the state SHALL hold.

Reset
REQ-026 While rst_n=0 at a clk edge, the block SHALL enter IDLE, set gnt=0, set last_winner=NUM_REQ-1 (so requester 0 is searched first) and clear the counters.
REQ-027 Reset SHALL abort any packet in progress, with no completion and no eof emitted.
REQ-028 During and after reset, in_rdy and out_vld SHALL be 0 until a new grant.

Configuration
REQ-029 With macro AVST_PKT_ARB_STATS_EN defined, the block SHALL add output pkt_cnt, NUM_REQ*32 bits, holding per-requester counts of eof beats transferred.
REQ-030 The pkt_cnt counters SHALL wrap at 2^32-1 to 0 and reset to 0.
REQ-031 Without AVST_PKT_ARB_STATS_EN, the pkt_cnt port and its counter logic SHALL be absent.

Structure
REQ-032 Package avst_pkt_arb_pkg SHALL hold the state enum (IDLE, LOCKED), the CNT_WIDTH=32 constant and the round-robin search function.
REQ-033 The block SHALL use one sub-module, rr_arbiter: NUM_REQ-wide round-robin priority pick taking request and last_winner, producing a one-hot winner; it is purely combinational.

Verification
REQ-034 Reset, then in_vld=4'b0010 with a 3-beat packet on requester 1 and out_rdy=1 -> gnt=0010 one cycle later; 3 beats out in order; IDLE after eof.
REQ-035 All four requesters hold continuous 1-beat packets -> grant order 0,1,2,3,0,... with one bubble between packets.
REQ-036 Requester 0 is mid-packet (beat 2 of 5) when requester 2 asserts in_vld -> no grant change until requester 0's eof transfers; then requester 2 is granted.
REQ-037 out_rdy=0 for 4 cycles mid-packet -> out_* stable, in_rdy[g]=0, no beat lost or duplicated.
REQ-038 rst_n=0 asserted during beat 2 of a packet -> next cycle gnt=0, out_vld=0, in_rdy=0; after release, requester 0 wins if valid.
REQ-039 With AVST_PKT_ARB_STATS_EN defined, send 5 packets on requester 3 -> pkt_cnt slice 3 = 5 and all other slices = 0.
